// File: rtl/imu_frame_builder.sv
// -----------------------------------------------------------------------------
// imu_frame_builder
//
// Snapshot/frame buffer that sits between N IMU controllers and the MCU SPI
// slave. Each sensor's latest quaternion and gyro samples are held in shadow
// registers, together with freshness flags, staleness counters and an 8-bit
// quaternion sequence number. A snap_req copies every sensor, one per cycle,
// into the back bank of a double-buffered frame. When the copy is complete
// and the MCU is not reading, the banks swap. The MCU only ever reads the
// front bank, so a frame can never tear.
//
// Frame record for sensor i starts at byte 16*i:
//   b0      {qfresh, gfresh, qstale, gstale, 4'b0}
//   b1      seq[i]
//   b2..9   quat w, x, y, z (MSB first)
//   b10..15 gyro x, y, z    (MSB first)
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   quat_valid    per-sensor 1-cycle quaternion strobe
//   quat_w/x/y/z  packed quaternion components, sensor i at [16i+15:16i]
//   gyro_valid    per-sensor 1-cycle gyro strobe
//   gyro_x/y/z    packed gyro components, sensor i at [16i+15:16i]
//   snap_req      1-cycle pulse requesting a snapshot
//   rd_lock       high while the MCU reads a frame; holds off the bank swap
//   rd_addr       frame byte address
//   rd_data       frame byte, one cycle after rd_addr
//   snap_busy     high from an accepted snap_req until the swap completes
//   snap_done     1-cycle pulse on bank swap
//   snap_overrun  1-cycle pulse one cycle after a snap_req dropped while busy
//   frame_count   number of completed swaps, wraps
//   any_stale     OR of all per-sensor stale flags
// -----------------------------------------------------------------------------
module imu_frame_builder #(
    parameter int N_SENSORS    = 2,
    parameter int STALE_CYCLES = 300000,
    parameter int FRAME_CNT_W  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [N_SENSORS-1:0]             quat_valid,
    input  logic [N_SENSORS*16-1:0]          quat_w,
    input  logic [N_SENSORS*16-1:0]          quat_x,
    input  logic [N_SENSORS*16-1:0]          quat_y,
    input  logic [N_SENSORS*16-1:0]          quat_z,
    input  logic [N_SENSORS-1:0]             gyro_valid,
    input  logic [N_SENSORS*16-1:0]          gyro_x,
    input  logic [N_SENSORS*16-1:0]          gyro_y,
    input  logic [N_SENSORS*16-1:0]          gyro_z,
    input  logic                             snap_req,
    input  logic                             rd_lock,
    input  logic [$clog2(N_SENSORS*16)-1:0]  rd_addr,
    output logic [7:0]                       rd_data,
    output logic                             snap_busy,
    output logic                             snap_done,
    output logic                             snap_overrun,
    output logic [FRAME_CNT_W-1:0]           frame_count,
    output logic                             any_stale
);

    localparam int FRAME_BYTES = N_SENSORS * 16;
    localparam int ADDR_W      = $clog2(FRAME_BYTES);
    localparam int K_W         = (N_SENSORS > 1) ? $clog2(N_SENSORS) : 1;
    localparam int CNT_W       = $clog2(STALE_CYCLES + 1);

    localparam logic [CNT_W-1:0] STALE_MAX = CNT_W'(STALE_CYCLES);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(N_SENSORS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COPY,
        ST_SWAP
    } state_t;

    // Shadow registers: latest sample per sensor.
    logic [15:0]          r_qw   [N_SENSORS];
    logic [15:0]          r_qx   [N_SENSORS];
    logic [15:0]          r_qy   [N_SENSORS];
    logic [15:0]          r_qz   [N_SENSORS];
    logic [15:0]          r_gx   [N_SENSORS];
    logic [15:0]          r_gy   [N_SENSORS];
    logic [15:0]          r_gz   [N_SENSORS];
    logic [7:0]           r_seq  [N_SENSORS];
    logic [CNT_W-1:0]     r_qcnt [N_SENSORS];
    logic [CNT_W-1:0]     r_gcnt [N_SENSORS];
    logic [N_SENSORS-1:0] r_qfresh;
    logic [N_SENSORS-1:0] r_gfresh;

    // Snapshot FSM and frame storage.
    state_t               r_state;
    logic [K_W-1:0]       r_k;
    logic                 r_front;
    logic [7:0]           r_bank [2][FRAME_BYTES];

    logic [N_SENSORS-1:0] w_qstale;
    logic [N_SENSORS-1:0] w_gstale;
    logic [N_SENSORS-1:0] w_copy_sel;
    logic [7:0]           w_rec [16];

    // -------------------------------------------------------------------------
    // Per-sensor status decode
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_qstale   = '0;
        w_gstale   = '0;
        w_copy_sel = '0;
        for (int i = 0; i < N_SENSORS; i++) begin
            w_qstale[i]   = (r_qcnt[i] == STALE_MAX);
            w_gstale[i]   = (r_gcnt[i] == STALE_MAX);
            w_copy_sel[i] = (r_state == ST_COPY) && (r_k == K_W'(i));
        end
    end

    assign any_stale = (|w_qstale) | (|w_gstale);
    assign snap_busy = (r_state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Shadow capture, freshness and staleness
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_qfresh <= '0;
            r_gfresh <= '0;
            for (int i = 0; i < N_SENSORS; i++) begin
                r_qw[i]   <= '0;
                r_qx[i]   <= '0;
                r_qy[i]   <= '0;
                r_qz[i]   <= '0;
                r_gx[i]   <= '0;
                r_gy[i]   <= '0;
                r_gz[i]   <= '0;
                r_seq[i]  <= '0;
                // Channels report stale until their first strobe arrives.
                r_qcnt[i] <= STALE_MAX;
                r_gcnt[i] <= STALE_MAX;
            end
        end else begin
            for (int i = 0; i < N_SENSORS; i++) begin
                // NOTE: non-blocking assignments, and the last one in program
                // order wins, so a strobe in the same cycle as the copy of
                // this sensor leaves its fresh flag set.
                if (w_copy_sel[i]) begin
                    r_qfresh[i] <= 1'b0;
                    r_gfresh[i] <= 1'b0;
                end

                if (quat_valid[i]) begin
                    r_qw[i]     <= quat_w[16*i +: 16];
                    r_qx[i]     <= quat_x[16*i +: 16];
                    r_qy[i]     <= quat_y[16*i +: 16];
                    r_qz[i]     <= quat_z[16*i +: 16];
                    r_qfresh[i] <= 1'b1;
                    r_seq[i]    <= r_seq[i] + 8'd1;
                    r_qcnt[i]   <= '0;
                end else if (r_qcnt[i] != STALE_MAX) begin
                    r_qcnt[i]   <= r_qcnt[i] + CNT_W'(1);
                end

                if (gyro_valid[i]) begin
                    r_gx[i]     <= gyro_x[16*i +: 16];
                    r_gy[i]     <= gyro_y[16*i +: 16];
                    r_gz[i]     <= gyro_z[16*i +: 16];
                    r_gfresh[i] <= 1'b1;
                    r_gcnt[i]   <= '0;
                end else if (r_gcnt[i] != STALE_MAX) begin
                    r_gcnt[i]   <= r_gcnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Record for the sensor currently being copied (pre-update shadow values)
    // -------------------------------------------------------------------------
    always_comb begin
        w_rec[0]  = {r_qfresh[r_k], r_gfresh[r_k], w_qstale[r_k], w_gstale[r_k], 4'b0000};
        w_rec[1]  = r_seq[r_k];
        w_rec[2]  = r_qw[r_k][15:8];
        w_rec[3]  = r_qw[r_k][7:0];
        w_rec[4]  = r_qx[r_k][15:8];
        w_rec[5]  = r_qx[r_k][7:0];
        w_rec[6]  = r_qy[r_k][15:8];
        w_rec[7]  = r_qy[r_k][7:0];
        w_rec[8]  = r_qz[r_k][15:8];
        w_rec[9]  = r_qz[r_k][7:0];
        w_rec[10] = r_gx[r_k][15:8];
        w_rec[11] = r_gx[r_k][7:0];
        w_rec[12] = r_gy[r_k][15:8];
        w_rec[13] = r_gy[r_k][7:0];
        w_rec[14] = r_gz[r_k][15:8];
        w_rec[15] = r_gz[r_k][7:0];
    end

    // -------------------------------------------------------------------------
    // Snapshot FSM: copy one sensor per cycle into the back bank, then swap
    // once the MCU releases rd_lock.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_front      <= 1'b0;
            frame_count  <= '0;
            snap_done    <= 1'b0;
            snap_overrun <= 1'b0;
            // NOTE: the frame banks are reset on purpose: after reset the MCU
            // must read zeros, never stale contents of a half-built frame.
            for (int b = 0; b < 2; b++) begin
                for (int a = 0; a < FRAME_BYTES; a++) begin
                    r_bank[b][a] <= '0;
                end
            end
        end else begin
            snap_done    <= 1'b0;
            snap_overrun <= snap_req && (r_state != ST_IDLE);

            case (r_state)
                ST_IDLE: begin
                    if (snap_req) begin
                        r_state <= ST_COPY;
                        r_k     <= '0;
                    end
                end

                ST_COPY: begin
                    for (int j = 0; j < 16; j++) begin
                        r_bank[~r_front][ADDR_W'(int'(r_k) * 16 + j)] <= w_rec[j];
                    end
                    if (r_k == K_LAST) begin
                        r_state <= ST_SWAP;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end

                ST_SWAP: begin
                    if (!rd_lock) begin
                        r_front     <= ~r_front;
                        frame_count <= frame_count + FRAME_CNT_W'(1);
                        snap_done   <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Front-bank read port, one cycle latency; out-of-range reads return 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= '0;
        end else if ({1'b0, rd_addr} < (ADDR_W + 1)'(FRAME_BYTES)) begin
            rd_data <= r_bank[r_front][rd_addr];
        end else begin
            rd_data <= '0;
        end
    end

endmodule

// File: tb/tb_imu_frame_builder.sv
// -----------------------------------------------------------------------------
// tb_imu_frame_builder
//
// Self-checking bench for imu_frame_builder with two sensors and a short
// stale timeout. Frame reads go through a scoreboard queue: the expected byte
// is pushed when rd_addr is driven and popped when rd_data is sampled.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_imu_frame_builder;

    localparam int N     = 2;
    localparam int STALE = 200;
    localparam int FB    = N * 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    quat_valid = '0;
    logic [N*16-1:0] quat_w = '0, quat_x = '0, quat_y = '0, quat_z = '0;
    logic [N-1:0]    gyro_valid = '0;
    logic [N*16-1:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
    logic            snap_req = 1'b0;
    logic            rd_lock = 1'b0;
    logic [4:0]      rd_addr = '0;
    logic [7:0]      rd_data;
    logic            snap_busy;
    logic            snap_done;
    logic            snap_overrun;
    logic [7:0]      frame_count;
    logic            any_stale;

    always #5 clk = ~clk;

    imu_frame_builder #(
        .N_SENSORS    (N),
        .STALE_CYCLES (STALE),
        .FRAME_CNT_W  (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .quat_valid   (quat_valid),
        .quat_w       (quat_w),
        .quat_x       (quat_x),
        .quat_y       (quat_y),
        .quat_z       (quat_z),
        .gyro_valid   (gyro_valid),
        .gyro_x       (gyro_x),
        .gyro_y       (gyro_y),
        .gyro_z       (gyro_z),
        .snap_req     (snap_req),
        .rd_lock      (rd_lock),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .snap_busy    (snap_busy),
        .snap_done    (snap_done),
        .snap_overrun (snap_overrun),
        .frame_count  (frame_count),
        .any_stale    (any_stale)
    );

    typedef struct {
        int         addr;
        logic [7:0] exp;
    } rd_vec_t;

    int      n_checks = 0;
    int      n_pass   = 0;
    rd_vec_t vec_q[$];
    rd_vec_t sb_q[$];
    rd_vec_t s0_tbl[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic add_vec(input int addr, input logic [7:0] exp);
        rd_vec_t v;
        v.addr = addr;
        v.exp  = exp;
        vec_q.push_back(v);
    endtask

    // Drive each queued address, push its expectation, pop and compare one
    // cycle later when rd_data carries that byte.
    task automatic read_vecs(input string tag);
        rd_vec_t v;
        rd_vec_t e;
        while (vec_q.size() > 0) begin
            v       = vec_q.pop_front();
            rd_addr = 5'(v.addr);
            sb_q.push_back(v);
            @(negedge clk);
            e = sb_q.pop_front();
            check($sformatf("%s byte %0d", tag, e.addr), 32'(rd_data), 32'(e.exp));
        end
    endtask

    task automatic set_quat(input int s, input logic [15:0] w, input logic [15:0] x,
                            input logic [15:0] y, input logic [15:0] z);
        quat_w[16*s +: 16] = w;
        quat_x[16*s +: 16] = x;
        quat_y[16*s +: 16] = y;
        quat_z[16*s +: 16] = z;
    endtask

    task automatic set_gyro(input int s, input logic [15:0] x, input logic [15:0] y,
                            input logic [15:0] z);
        gyro_x[16*s +: 16] = x;
        gyro_y[16*s +: 16] = y;
        gyro_z[16*s +: 16] = z;
    endtask

    // Pulse snap_req and count cycles until snap_done (bounded).
    task automatic do_snap(input string tag);
        int lat;
        snap_req = 1'b1;
        @(negedge clk);
        snap_req = 1'b0;
        check({tag, " busy"}, 32'(snap_busy), 32'd1);
        lat = 0;
        while (!snap_done && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int c;

        // Expected record for sensor 0 after the first snapshot, plus the
        // status byte of the never-strobed sensor 1.
        begin
            logic [7:0] bytes [17];
            bytes = '{8'hC0, 8'h01, 8'h03, 8'hE8, 8'hFF, 8'hFE, 8'h00, 8'h03,
                      8'h00, 8'h04, 8'h00, 8'h05, 8'h00, 8'h06, 8'hFF, 8'hF9,
                      8'h30};
            for (int i = 0; i < 17; i++) begin
                s0_tbl[i].addr = i;
                s0_tbl[i].exp  = bytes[i];
            end
        end

        // ---------------- reset state ----------------
        tick(3);
        rst_n = 1'b1;
        tick(1);
        check("rst any_stale", 32'(any_stale), 32'd1);
        check("rst snap_busy", 32'(snap_busy), 32'd0);
        check("rst snap_done", 32'(snap_done), 32'd0);
        check("rst snap_overrun", 32'(snap_overrun), 32'd0);
        check("rst frame_count", 32'(frame_count), 32'd0);
        for (int a = 0; a < FB; a++) add_vec(a, 8'h00);
        read_vecs("rst frame");

        // ---------------- first snapshot of sensor 0 ----------------
        set_quat(0, 16'd1000, 16'hFFFE, 16'd3, 16'd4);
        set_gyro(0, 16'd5, 16'd6, 16'hFFF9);
        quat_valid = 2'b01;
        gyro_valid = 2'b01;
        tick(1);
        quat_valid = '0;
        gyro_valid = '0;
        do_snap("snap1");
        check("snap1 frame_count", 32'(frame_count), 32'd1);
        tick(1);
        check("snap1 done pulse width", 32'(snap_done), 32'd0);
        check("snap1 busy cleared", 32'(snap_busy), 32'd0);
        for (int i = 0; i < 17; i++) add_vec(s0_tbl[i].addr, s0_tbl[i].exp);
        read_vecs("snap1");

        // ---------------- second snapshot: fresh flags cleared ----------------
        do_snap("snap2");
        check("snap2 frame_count", 32'(frame_count), 32'd2);
        add_vec(0, 8'h00);
        add_vec(1, 8'h01);
        add_vec(3, 8'hE8);
        read_vecs("snap2");

        // ---------------- 256 strobes on sensor 1: seq wrap, S0 goes stale ----
        set_quat(1, 16'hABCD, 16'h0000, 16'h0000, 16'h0000);
        quat_valid = 2'b10;
        tick(256);
        quat_valid = '0;
        do_snap("wrap");
        check("wrap any_stale", 32'(any_stale), 32'd1);
        add_vec(0, 8'h30);
        add_vec(1, 8'h01);
        add_vec(16, 8'h90);
        add_vec(17, 8'h00);
        add_vec(18, 8'hAB);
        add_vec(19, 8'hCD);
        read_vecs("wrap");

        // ---------------- any_stale boundary ----------------
        quat_valid = 2'b11;
        gyro_valid = 2'b11;
        tick(1);
        quat_valid = '0;
        gyro_valid = '0;
        check("stale after strobe", 32'(any_stale), 32'd0);
        tick(STALE - 1);
        check("stale at limit-1", 32'(any_stale), 32'd0);
        tick(1);
        check("stale at limit", 32'(any_stale), 32'd1);

        // ---------------- rd_lock holds the swap ----------------
        quat_valid = 2'b10;
        tick(1);
        quat_valid = '0;
        rd_lock  = 1'b1;
        rd_addr  = 5'd17;
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        tick(10);
        check("lock busy", 32'(snap_busy), 32'd1);
        check("lock no done", 32'(snap_done), 32'd0);
        check("lock frame_count", 32'(frame_count), 32'd3);
        check("lock rd_data old", 32'(rd_data), 32'h00);
        rd_lock = 1'b0;
        tick(1);
        check("unlock done", 32'(snap_done), 32'd1);
        check("unlock frame_count", 32'(frame_count), 32'd4);
        check("unlock rd_data swap edge", 32'(rd_data), 32'h00);
        tick(1);
        check("unlock rd_data new", 32'(rd_data), 32'h02);

        // ---------------- overrun + strobe coincident with COPY k=0 --------
        snap_req = 1'b1;
        tick(1);
        set_quat(0, 16'h7777, 16'h0000, 16'h0000, 16'h0000);
        quat_valid = 2'b01;
        check("ovr idle pulse", 32'(snap_overrun), 32'd0);
        tick(1);
        snap_req   = 1'b0;
        quat_valid = '0;
        check("ovr pulse", 32'(snap_overrun), 32'd1);
        tick(1);
        check("ovr pulse width", 32'(snap_overrun), 32'd0);
        c = 0;
        while (!snap_done && c < 20) begin
            tick(1);
            c++;
        end
        check("ovr done seen", 32'(snap_done), 32'd1);
        check("ovr frame_count", 32'(frame_count), 32'd5);
        tick(1);
        check("ovr no second swap", 32'(snap_busy), 32'd0);
        add_vec(0, 8'h30);
        add_vec(1, 8'h02);
        add_vec(2, 8'h03);
        add_vec(3, 8'hE8);
        read_vecs("coincident");
        do_snap("follow");
        check("follow frame_count", 32'(frame_count), 32'd6);
        add_vec(0, 8'h90);
        add_vec(1, 8'h03);
        add_vec(2, 8'h77);
        add_vec(3, 8'h77);
        read_vecs("follow");

        // ---------------- async reset mid-COPY ----------------
        snap_req = 1'b1;
        tick(1);
        snap_req = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("midrst busy", 32'(snap_busy), 32'd0);
        check("midrst done", 32'(snap_done), 32'd0);
        check("midrst frame_count", 32'(frame_count), 32'd0);
        check("midrst any_stale", 32'(any_stale), 32'd1);
        check("midrst rd_data", 32'(rd_data), 32'h00);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        for (int a = 0; a < FB; a++) add_vec(a, 8'h00);
        read_vecs("midrst frame");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
